muldiv_issue_ctrl: RTL

- Issue/writeback controller sitting directly upstream of the iterative 32-bit unsigned multiply/divide unit in the CPU execute stage.
- Accepts a decoded MUL/MULHU/DIVU/REMU request from the core and stalls the pipeline for the duration of the operation.
- Launches the unit with a one-cycle valid pulse, captures its 64-bit result, selects the architectural 32-bit half and issues a single-cycle register writeback.
- Divide-by-zero is resolved locally without launching the unit.

---
 rtl/muldiv_issue_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_issue_ctrl.sv
// Issue/writeback controller for the iterative 32-bit unsigned mul/div unit.
// Optional last-result reuse cache enabled by defining MULDIV_RESULT_REUSE_EN.
module muldiv_issue_ctrl #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [RD_W-1:0]   rd,
    output logic              stall,
    output logic              wb_en,
    output logic [RD_W-1:0]   wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              md_valid,
    output logic              md_mode,
    output logic [XLEN-1:0]   md_a,
    output logic [XLEN-1:0]   md_b,
    input  logic              md_ready,
    input  logic [2*XLEN-1:0] md_out
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        WB
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, res_q;
    logic [RD_W-1:0] rd_q;

    logic            div_zero;
    logic [XLEN-1:0] zero_res;
    logic            reuse_hit;

    // RISC-V divide-by-zero: DIVU gives all ones, REMU returns the dividend.
    assign div_zero = op[1] && (rs2_data == '0);
    assign zero_res = op[0] ? rs1_data : '1;

`ifdef MULDIV_RESULT_REUSE_EN
    logic              last_vld;
    logic              last_mode;
    logic [XLEN-1:0]   last_a, last_b;
    logic [2*XLEN-1:0] last_result;
    logic [XLEN-1:0]   reuse_res;

    assign reuse_hit = last_vld && (op[1] == last_mode) &&
                       (rs1_data == last_a) && (rs2_data == last_b);
    assign reuse_res = op[0] ? last_result[2*XLEN-1:XLEN] : last_result[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld    <= 1'b0;
            last_mode   <= 1'b0;
            last_a      <= '0;
            last_b      <= '0;
            last_result <= '0;
        end else if (state == WAIT && md_ready) begin
            last_vld    <= 1'b1;
            last_mode   <= op_q[1];
            last_a      <= a_q;
            last_b      <= b_q;
            last_result <= md_out;
        end
    end
`else
    assign reuse_hit = 1'b0;
`endif

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rd_q  <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_q <= op;
                        a_q  <= rs1_data;
                        b_q  <= rs2_data;
                        rd_q <= rd;
                        if (div_zero) begin
                            res_q <= zero_res;
                        end
`ifdef MULDIV_RESULT_REUSE_EN
                        else if (reuse_hit) begin
                            res_q <= reuse_res;
                        end
`endif
                    end
                end
                WAIT: begin
                    if (md_ready) begin
                        res_q <= op_q[0] ? md_out[2*XLEN-1:XLEN] : md_out[XLEN-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output and the next state get a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        md_valid  = 1'b0;
        md_mode   = 1'b0;
        md_a      = '0;
        md_b      = '0;
        wb_en     = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        case (state)
            IDLE: begin
                // Gated by rst_n so every output reads 0 while reset is held.
                stall = req && rst_n;
                if (req) begin
                    state_nxt = (div_zero || reuse_hit) ? WB : LAUNCH;
                end
            end
            LAUNCH: begin
                stall     = 1'b1;
                md_valid  = 1'b1;
                md_mode   = op_q[1];
                md_a      = a_q;
                md_b      = b_q;
                state_nxt = WAIT;
            end
            WAIT: begin
                stall   = 1'b1;
                md_mode = op_q[1];
                md_a    = a_q;
                md_b    = b_q;
                if (md_ready) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                wb_en     = (rd_q != '0);
                wb_rd     = rd_q;
                wb_data   = (rd_q != '0) ? res_q : '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
